// File: rtl/data_memory_controller.sv
// rtl/data_memory_controller.sv - handshaked multicycle data memory; define MISALIGNED_SPLIT_EN to execute misaligned accesses as two word accesses
module data_memory_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 32768
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_format,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Last byte address that belongs to the RAM, kept in 33 bits so the sum check never wraps.
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4 - 33'd1;

`ifdef MISALIGNED_SPLIT_EN
  localparam int unsigned SPAN = 8;
`else
  localparam int unsigned SPAN = 4;
`endif
  localparam int unsigned DW = 8 * SPAN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_RESP,
    S_ERR
`ifdef MISALIGNED_SPLIT_EN
    , S_HI
`endif
  } state_t;

  state_t          state_q;
  logic            ready_q;
  logic            resp_valid_q;
  logic            resp_error_q;
  logic            write_q;
  logic [2:0]      format_q;
  logic [1:0]      off_q;
  logic [AW-1:0]   word_q;
  logic [SPAN-1:0] mask_q;
  logic [DW-1:0]   sdata_q;
  logic [31:0]     lo_q;
`ifdef MISALIGNED_SPLIT_EN
  logic            split_q;
  logic [31:0]     hi_q;
  logic [AW-1:0]   word_hi;
`endif

  logic [31:0]     mem [0:DEPTH_WORDS-1];

  logic [2:0]      req_size;
  logic [3:0]      size_mask;
  logic [32:0]     req_end;
  logic            req_in_range;
  logic            req_split;
  logic            req_err;
  logic [SPAN-1:0] req_mask;
  logic [DW-1:0]   req_sdata;
  logic [AW-1:0]   req_word;

  // Decode the incoming request: size, legality, split need, byte lanes and shifted data.
  always_comb begin
    req_size  = 3'd4;
    size_mask = 4'hF;
    case (req_format[1:0])
      2'b00: begin req_size = 3'd1; size_mask = 4'h1; end
      2'b01: begin req_size = 3'd2; size_mask = 4'h3; end
      default: begin req_size = 3'd4; size_mask = 4'hF; end
    endcase
    req_end      = {1'b0, req_address} + {30'd0, req_size} - 33'd1;
    req_in_range = (req_address >= BASE_ADDR) && (req_end <= LAST_ADDR);
    req_split    = ({1'b0, req_address[1:0]} + req_size) > 3'd4;
    req_mask     = SPAN'(size_mask) << req_address[1:0];
    req_sdata    = DW'(req_write_data) << {req_address[1:0], 3'b000};
    req_word     = AW'((req_address - BASE_ADDR) >> 2);
`ifdef MISALIGNED_SPLIT_EN
    req_err      = (req_format[1:0] == 2'b11) || !req_in_range;
`else
    req_err      = (req_format[1:0] == 2'b11) || !req_in_range || req_split;
`endif
  end

`ifdef MISALIGNED_SPLIT_EN
  assign word_hi = word_q + AW'(1);
`endif

  // Control FSM: latches the request on accept and produces the registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      write_q      <= 1'b0;
      format_q     <= 3'd0;
      off_q        <= 2'd0;
      word_q       <= '0;
      mask_q       <= '0;
      sdata_q      <= '0;
`ifdef MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            ready_q  <= 1'b0;
            write_q  <= req_write;
            format_q <= req_format;
            off_q    <= req_address[1:0];
            word_q   <= req_word;
            mask_q   <= req_mask;
            sdata_q  <= req_sdata;
`ifdef MISALIGNED_SPLIT_EN
            split_q  <= req_split;
`endif
            if (req_err) begin
              state_q      <= S_ERR;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else begin
              state_q <= S_LO;
            end
          end
        end
        S_LO: begin
`ifdef MISALIGNED_SPLIT_EN
          if (split_q) begin
            state_q <= S_HI;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end
`else
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
`endif
        end
`ifdef MISALIGNED_SPLIT_EN
        S_HI: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
        end
`endif
        S_RESP, S_ERR: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // RAM port: synchronous read into lo_q/hi_q and byte-enabled writes during LO and HI.
  always_ff @(posedge clock) begin
    if (state_q == S_LO) begin
      lo_q <= mem[word_q];
`ifdef MISALIGNED_SPLIT_EN
      hi_q <= 32'd0;
`endif
      for (int b = 0; b < 4; b++) begin
        if (write_q && mask_q[b]) begin
          mem[word_q][8*b +: 8] <= sdata_q[8*b +: 8];
        end
      end
    end
`ifdef MISALIGNED_SPLIT_EN
    if (state_q == S_HI) begin
      hi_q <= mem[word_hi];
      for (int b = 0; b < 4; b++) begin
        if (write_q && mask_q[4+b]) begin
          mem[word_hi][8*b +: 8] <= sdata_q[32+8*b +: 8];
        end
      end
    end
`endif
  end

  logic [63:0] pair;
  logic [63:0] shifted;
  logic [31:0] load_val;

  // Align the captured word(s) to the access offset and extend; zero whenever no load response is shown.
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    pair = {hi_q, lo_q};
`else
    pair = {32'd0, lo_q};
`endif
    shifted = pair >> {off_q, 3'b000};
    case (format_q[1:0])
      2'b00:   load_val = format_q[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = format_q[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted[31:0];
    endcase
    resp_data = (resp_valid_q && !resp_error_q && !write_q) ? load_val : 32'd0;
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// tb/tb_data_memory_controller.sv - directed scoreboard bench for data_memory_controller
module tb_data_memory_controller;

  localparam logic [31:0] B     = 32'h0001_0000;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] TOP   = B + 32'(DEPTH) * 32'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_format;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  data_memory_controller #(
    .BASE_ADDR   (B),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_format     (req_format),
    .req_address    (req_address),
    .req_write_data (req_write_data),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_error     (resp_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one request at a negedge, then wait (bounded) for the response and compare against the scoreboard head.
  task automatic do_req(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_data, input int exp_lat);
    int   n;
    int   k;
    bit   seen;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
    sb_q.push_back('{err: exp_err, data: exp_data, lat: exp_lat, tag: tag});
    req_valid      = 1'b1;
    req_write      = w;
    req_format     = f;
    req_address    = a;
    req_write_data = d;
    @(posedge clock);
    @(negedge clock);
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_write_data = 32'hBAD0_BAD0;
    if (exp_lat > 1) check({tag, "/busy"}, {31'd0, req_ready}, 32'd0);
    k    = 1;
    seen = 1'b0;
    while (!seen && k <= 8) begin
      if (resp_valid === 1'b1) seen = 1'b1;
      else begin
        @(negedge clock);
        k++;
      end
    end
    e = sb_q.pop_front();
    check({e.tag, "/seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({e.tag, "/lat"}, k, e.lat);
      check({e.tag, "/err"}, {31'd0, resp_error}, {31'd0, e.err});
      check({e.tag, "/data"}, resp_data, e.data);
      @(negedge clock);
      check({e.tag, "/pulse"}, {31'd0, resp_valid}, 32'd0);
      check({e.tag, "/idle_data"}, resp_data, 32'd0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_format     = 3'd0;
    req_address    = 32'd0;
    req_write_data = 32'd0;
    repeat (2) @(negedge clock);
    check("rst/ready", {31'd0, req_ready}, 32'd1);
    check("rst/valid", {31'd0, resp_valid}, 32'd0);
    check("rst/error", {31'd0, resp_error}, 32'd0);
    check("rst/data", resp_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Reset asserted while a load sits in LO: no response may follow.
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_format  = 3'b010;
    req_address = B;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("midlo/busy", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("midlo/ready", {31'd0, req_ready}, 32'd1);
    check("midlo/valid", {31'd0, resp_valid}, 32'd0);
    check("midlo/error", {31'd0, resp_error}, 32'd0);
    check("midlo/data", resp_data, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("midlo/noresp", {31'd0, resp_valid}, 32'd0);
    end

    // Aligned store/load and extension of sub-word loads.
    do_req("st_w0", 1'b1, 3'b010, B, 32'hDEADBEEF, 1'b0, 32'd0, 2);
    do_req("ld_w0", 1'b0, 3'b010, B, 32'd0, 1'b0, 32'hDEADBEEF, 2);
    do_req("ld_b3s", 1'b0, 3'b000, B + 32'd3, 32'd0, 1'b0, 32'hFFFFFFDE, 2);
    do_req("ld_b3z", 1'b0, 3'b100, B + 32'd3, 32'd0, 1'b0, 32'h000000DE, 2);
    do_req("ld_h2s", 1'b0, 3'b001, B + 32'd2, 32'd0, 1'b0, 32'hFFFFDEAD, 2);
    do_req("ld_h2z", 1'b0, 3'b101, B + 32'd2, 32'd0, 1'b0, 32'h0000DEAD, 2);
    do_req("ld_h1s", 1'b0, 3'b001, B + 32'd1, 32'd0, 1'b0, 32'hFFFFADBE, 2);
    do_req("ld_b0s", 1'b0, 3'b000, B, 32'd0, 1'b0, 32'hFFFFFFEF, 2);

    do_req("st_w1", 1'b1, 3'b010, B + 32'd4, 32'h11223344, 1'b0, 32'd0, 2);
    do_req("st_w2", 1'b1, 3'b010, B + 32'd8, 32'h55667788, 1'b0, 32'd0, 2);
    do_req("st_b5", 1'b1, 3'b000, B + 32'd5, 32'h000000C3, 1'b0, 32'd0, 2);
    do_req("ld_w1a", 1'b0, 3'b010, B + 32'd4, 32'd0, 1'b0, 32'h1122C344, 2);

    // Half store straddling words 1 and 2.
`ifdef MISALIGNED_SPLIT_EN
    do_req("st_h7", 1'b1, 3'b001, B + 32'd7, 32'h0000A55A, 1'b0, 32'd0, 3);
    do_req("ld_w1", 1'b0, 3'b010, B + 32'd4, 32'd0, 1'b0, 32'h5A22C344, 2);
    do_req("ld_w2", 1'b0, 3'b010, B + 32'd8, 32'd0, 1'b0, 32'h556677A5, 2);
    do_req("ld_h7", 1'b0, 3'b001, B + 32'd7, 32'd0, 1'b0, 32'hFFFFA55A, 3);
    do_req("ld_w5", 1'b0, 3'b010, B + 32'd5, 32'd0, 1'b0, 32'hA55A22C3, 3);
`else
    do_req("st_h7", 1'b1, 3'b001, B + 32'd7, 32'h0000A55A, 1'b1, 32'd0, 1);
    do_req("ld_w1", 1'b0, 3'b010, B + 32'd4, 32'd0, 1'b0, 32'h1122C344, 2);
    do_req("ld_w2", 1'b0, 3'b010, B + 32'd8, 32'd0, 1'b0, 32'h55667788, 2);
    do_req("ld_h7", 1'b0, 3'b001, B + 32'd7, 32'd0, 1'b1, 32'd0, 1);
`endif

    // Range and format errors, plus the last legal word.
    do_req("ld_top2", 1'b0, 3'b010, TOP - 32'd2, 32'd0, 1'b1, 32'd0, 1);
    do_req("ld_bm1", 1'b0, 3'b010, B - 32'd1, 32'd0, 1'b1, 32'd0, 1);
    do_req("ld_f11", 1'b0, 3'b011, B, 32'd0, 1'b1, 32'd0, 1);
    do_req("st_f11", 1'b1, 3'b011, B, 32'h01234567, 1'b1, 32'd0, 1);
    do_req("st_bm4", 1'b1, 3'b010, B - 32'd4, 32'h89ABCDEF, 1'b1, 32'd0, 1);
    do_req("ld_w0b", 1'b0, 3'b010, B, 32'd0, 1'b0, 32'hDEADBEEF, 2);
    do_req("st_last", 1'b1, 3'b010, TOP - 32'd4, 32'hCAFEF00D, 1'b0, 32'd0, 2);
    do_req("ld_last", 1'b0, 3'b010, TOP - 32'd4, 32'd0, 1'b0, 32'hCAFEF00D, 2);
    do_req("ld_lastb", 1'b0, 3'b100, TOP - 32'd1, 32'd0, 1'b0, 32'h000000CA, 2);
    do_req("ld_lasth", 1'b0, 3'b001, TOP - 32'd1, 32'd0, 1'b1, 32'd0, 1);
    do_req("st_toph", 1'b1, 3'b001, TOP, 32'h00001234, 1'b1, 32'd0, 1);
    do_req("ld_last2", 1'b0, 3'b010, TOP - 32'd4, 32'd0, 1'b0, 32'hCAFEF00D, 2);

    check("sb/empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
